// File: rtl/leaky_relu_vector_unit.sv
// -----------------------------------------------------------------------------
// leaky_relu_vector_unit
//   Multi-lane leaky-ReLU engine: forward activation, gradient-gated derivative,
//   derivative mask or passthrough, selected per beat. Signed fixed point with
//   round-half-up and saturation. Two-stage pipeline with valid/ready flow
//   control.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  input beat handshake (in_ready combinational from out_ready)
//   mode            00 forward, 01 grad-gated derivative, 10 mask, 11 passthrough
//   leak            alpha, signed Qx.FRAC, captured with each beat
//   x_in, g_in      per-lane h and g, lane i at [i*WIDTH +: WIDTH]
//   out_valid/ready output beat handshake
//   y_out           per-lane result, same packing as x_in
//   sat_flag        sticky: some lane saturated since the last sat_clr
//   sat_clr         synchronous clear of sat_flag (a new saturation wins)
// -----------------------------------------------------------------------------
module leaky_relu_vector_unit #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                mode,
  input  logic signed [WIDTH-1:0]   leak,
  input  logic [LANES*WIDTH-1:0]    x_in,
  input  logic [LANES*WIDTH-1:0]    g_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WIDTH-1:0]    y_out,
  output logic                      sat_flag,
  input  logic                      sat_clr
);

  localparam int PW = 2 * WIDTH;

  localparam logic signed [PW-1:0]    HALF  = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [PW-1:0]    MAXV  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0]    MINV  = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  // Round half up: add half an LSB of the result, then floor via arithmetic shift.
  function automatic logic signed [PW-1:0] f_round(input logic signed [PW-1:0] p);
    return (p + HALF) >>> FRAC;
  endfunction

  function automatic logic f_ovf(input logic signed [PW-1:0] r);
    return (r > MAXV) || (r < MINV);
  endfunction

  function automatic logic signed [WIDTH-1:0] f_sat(input logic signed [PW-1:0] r);
    if (r > MAXV)      return MAX_W;
    else if (r < MINV) return MIN_W;
    else               return r[WIDTH-1:0];
  endfunction

  // Flow control
  logic r_vld_p1, r_vld_p2, r_rdy_en;
  logic w_s1_adv, w_s2_adv, w_acc;

  assign w_s2_adv  = !r_vld_p2 || out_ready;
  assign w_s1_adv  = !r_vld_p1 || w_s2_adv;
  // r_rdy_en holds in_ready low while in reset and for the cycle it releases.
  assign in_ready  = r_rdy_en && w_s1_adv;
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_vld_p2;

  // ---- stage 0 -> 1: operand select and full-precision product ----
  logic signed [WIDTH-1:0] w_h    [LANES];
  logic signed [WIDTH-1:0] w_g    [LANES];
  logic signed [WIDTH-1:0] w_opnd [LANES];
  logic signed [PW-1:0]    w_ma   [LANES];
  logic signed [PW-1:0]    w_prod [LANES];
  logic signed [PW-1:0]    w_mb;
  logic [LANES-1:0]        w_neg;

  assign w_mb = {{WIDTH{leak[WIDTH-1]}}, leak};

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_h[i]   = x_in[i*WIDTH +: WIDTH];
      w_g[i]   = g_in[i*WIDTH +: WIDTH];
      w_neg[i] = w_h[i][WIDTH-1];
      // w_opnd is the result whenever no multiply is needed for this lane.
      case (mode)
        2'b00:   w_opnd[i] = w_h[i];
        2'b01:   w_opnd[i] = w_g[i];
        2'b10:   w_opnd[i] = w_neg[i] ? leak : ONE;
        default: w_opnd[i] = w_h[i];
      endcase
      w_ma[i]   = mode[0] ? {{WIDTH{w_g[i][WIDTH-1]}}, w_g[i]}
                          : {{WIDTH{w_h[i][WIDTH-1]}}, w_h[i]};
      w_prod[i] = w_ma[i] * w_mb;
    end
  end

  logic [1:0]              r_mode_p1;
  logic [LANES-1:0]        r_neg_p1;
  logic signed [WIDTH-1:0] r_opnd_p1 [LANES];
  logic signed [PW-1:0]    r_prod_p1 [LANES];

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mode_p1 <= mode;
      r_neg_p1  <= w_neg;
      for (int i = 0; i < LANES; i++) begin
        r_opnd_p1[i] <= w_opnd[i];
        r_prod_p1[i] <= w_prod[i];
      end
    end
  end

  // ---- stage 1 -> 2: round, saturate, select ----
  logic [LANES*WIDTH-1:0] w_y;
  logic [LANES-1:0]       w_sat_lane;
  logic                   w_mul_mode;
  logic                   w_sat_set;

  assign w_mul_mode = (r_mode_p1 == 2'b00) || (r_mode_p1 == 2'b01);

  always_comb begin
    w_y        = '0;
    w_sat_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_mul_mode && r_neg_p1[i]) begin
        w_y[i*WIDTH +: WIDTH] = f_sat(f_round(r_prod_p1[i]));
        w_sat_lane[i]         = f_ovf(f_round(r_prod_p1[i]));
      end else begin
        w_y[i*WIDTH +: WIDTH] = r_opnd_p1[i];
      end
    end
  end

  assign w_sat_set = r_vld_p1 && w_s2_adv && (|w_sat_lane);

  logic [LANES*WIDTH-1:0] r_y_p2;
  logic                   r_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_en <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_y_p2   <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_s1_adv) r_vld_p1 <= w_acc;
      if (w_s2_adv) begin
        r_vld_p2 <= r_vld_p1;
        // Only overwrite y_out with a real beat so the last result stays put.
        if (r_vld_p1) r_y_p2 <= w_y;
      end
      if (w_sat_set)    r_sat <= 1'b1;
      else if (sat_clr) r_sat <= 1'b0;
    end
  end

  assign y_out    = r_y_p2;
  assign sat_flag = r_sat;

endmodule

// File: tb/tb_leaky_relu_vector_unit.sv
// -----------------------------------------------------------------------------
// tb_leaky_relu_vector_unit
//   Directed bench for leaky_relu_vector_unit (WIDTH=16, FRAC=8, LANES=4).
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_leaky_relu_vector_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [15:0] leak;
  logic [63:0] x_in;
  logic [63:0] g_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] y_out;
  logic        sat_flag;
  logic        sat_clr;

  int nvec = 0;
  int nerr = 0;

  logic [1:0]  t_mode [8];
  logic [15:0] t_leak [8];
  logic [63:0] t_x    [8];
  logic [63:0] t_g    [8];
  logic [63:0] t_y    [8];

  leaky_relu_vector_unit #(.WIDTH(16), .FRAC(8), .LANES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .leak      (leak),
    .x_in      (x_in),
    .g_in      (g_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .sat_flag  (sat_flag),
    .sat_clr   (sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane 0 is the first argument.
  function automatic logic [63:0] ln(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One beat through an empty pipeline with out_ready held high.
  task automatic run_beat(input string tag, input logic [1:0] m, input logic [15:0] lk,
                          input logic [63:0] x, input logic [63:0] g,
                          input logic [63:0] ex, input logic clr2);
    mode = m; leak = lk; x_in = x; g_in = g; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sat_clr  = clr2;
    chk({tag, "_vld_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk({tag, "_vld_lat2"}, 64'(out_valid), 64'd1);
    chk({tag, "_y"}, y_out, ex);
    @(posedge clk); #1;
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  // Streams the 8 table beats; pat[c] is out_ready in loop cycle c.
  task automatic stream(input string tag, input logic [63:0] pat,
                        input logic want_full, input int want_cyc);
    int sent, rcvd, first, last, occ;
    logic prev_stall, saw_full, acc, xfer;
    logic [63:0] yhold;
    sent = 0; rcvd = 0; first = -1; last = -1;
    prev_stall = 1'b0; saw_full = 1'b0; yhold = '0;
    for (int c = 0; c < 64 && rcvd < 8; c++) begin
      out_ready = pat[c];
      in_valid  = (sent < 8);
      if (sent < 8) begin
        mode = t_mode[sent]; leak = t_leak[sent]; x_in = t_x[sent]; g_in = t_g[sent];
      end
      #1;
      occ = sent - rcvd;
      chk($sformatf("%s_in_ready_c%0d", tag, c), 64'(in_ready), 64'((occ < 2) || out_ready));
      if (prev_stall) begin
        chk($sformatf("%s_hold_vld_c%0d", tag, c), 64'(out_valid), 64'd1);
        chk($sformatf("%s_hold_y_c%0d", tag, c), y_out, yhold);
      end
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (!in_ready) saw_full = 1'b1;
      if (xfer) begin
        chk($sformatf("%s_y%0d", tag, rcvd), y_out, t_y[rcvd]);
        rcvd++;
        last = c;
      end
      if (acc) begin
        if (first < 0) first = c;
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      yhold      = y_out;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_received"}, 64'(rcvd), 64'd8);
    chk({tag, "_empty_after"}, 64'(out_valid), 64'd0);
    if (want_full) chk({tag, "_in_ready_dropped"}, 64'(saw_full), 64'd1);
    if (want_cyc > 0) chk({tag, "_cycles"}, 64'(last - first + 1), 64'(want_cyc));
  endtask

  initial begin
    // Beat table: mixes modes and leak values so each beat checks its own capture.
    t_mode[0] = 2'b11; t_leak[0] = 16'h0000; t_x[0] = ln(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    t_g[0] = '0;       t_y[0] = ln(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    t_mode[1] = 2'b00; t_leak[1] = 16'h0020; t_x[1] = ln(16'hFF00, 16'h0100, 16'h0000, 16'hFE00);
    t_g[1] = '0;       t_y[1] = ln(16'hFFE0, 16'h0100, 16'h0000, 16'hFFC0);
    t_mode[2] = 2'b10; t_leak[2] = 16'h0040; t_x[2] = ln(16'h8000, 16'h0001, 16'hFFFF, 16'h0000);
    t_g[2] = '0;       t_y[2] = ln(16'h0040, 16'h0100, 16'h0040, 16'h0100);
    t_mode[3] = 2'b01; t_leak[3] = 16'h0080; t_x[3] = ln(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001);
    t_g[3] = ln(16'h0200, 16'h0200, 16'hFE00, 16'hFE00);
    t_y[3] = ln(16'h0100, 16'h0200, 16'hFF00, 16'hFE00);
    t_mode[4] = 2'b11; t_leak[4] = 16'h7FFF; t_x[4] = ln(16'h8000, 16'h7FFF, 16'h0000, 16'hABCD);
    t_g[4] = '0;       t_y[4] = ln(16'h8000, 16'h7FFF, 16'h0000, 16'hABCD);
    t_mode[5] = 2'b00; t_leak[5] = 16'hFF80; t_x[5] = ln(16'hFE00, 16'h0200, 16'hFFFF, 16'h0000);
    t_g[5] = '0;       t_y[5] = ln(16'h0100, 16'h0200, 16'h0001, 16'h0000);
    t_mode[6] = 2'b00; t_leak[6] = 16'h0080; t_x[6] = ln(16'hFFFF, 16'hFFFE, 16'hFD00, 16'h7FFF);
    t_g[6] = '0;       t_y[6] = ln(16'h0000, 16'hFFFF, 16'hFE80, 16'h7FFF);
    t_mode[7] = 2'b10; t_leak[7] = 16'hFF00; t_x[7] = ln(16'h0000, 16'hFFFF, 16'h0100, 16'h8001);
    t_g[7] = '0;       t_y[7] = ln(16'h0100, 16'hFF00, 16'h0100, 16'hFF00);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; leak = '0;
    x_in = '0; g_in = '0; sat_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y_out", y_out, 64'd0);
    chk("rst_sat_flag", 64'(sat_flag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_early", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    run_beat("fwd", 2'b00, 16'h0020, ln(16'h0100, 16'hFF00, 16'h0000, 16'hFFFD), '0,
             ln(16'h0100, 16'hFFE0, 16'h0000, 16'h0000), 1'b0);
    chk("fwd_sat_flag", 64'(sat_flag), 64'd0);
    run_beat("grad", 2'b01, 16'h0020, ln(16'hFE00, 16'h0000, 16'h0300, 16'h8000),
             ln(16'h0100, 16'h0100, 16'h0100, 16'h0100),
             ln(16'h0020, 16'h0100, 16'h0100, 16'h0020), 1'b0);
    run_beat("mask", 2'b10, 16'h0020, ln(16'hFE00, 16'h0000, 16'h0300, 16'h8000), '0,
             ln(16'h0020, 16'h0100, 16'h0100, 16'h0020), 1'b0);
    run_beat("pass", 2'b11, 16'h0020, ln(16'hFE00, 16'h0000, 16'h0300, 16'h8000), '0,
             ln(16'hFE00, 16'h0000, 16'h0300, 16'h8000), 1'b0);
    chk("pass_sat_flag", 64'(sat_flag), 64'd0);

    run_beat("sat_neg", 2'b00, 16'h7FFF, ln(16'h8000, 16'h0000, 16'h0000, 16'h0000), '0,
             ln(16'h8000, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    chk("sat_neg_flag", 64'(sat_flag), 64'd1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("sat_clr_flag", 64'(sat_flag), 64'd0);

    run_beat("sat_pos", 2'b00, 16'h8000, ln(16'h8000, 16'h0100, 16'h0000, 16'h0000), '0,
             ln(16'h7FFF, 16'h0100, 16'h0000, 16'h0000), 1'b1);
    chk("sat_set_wins", 64'(sat_flag), 64'd1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("sat_clr2_flag", 64'(sat_flag), 64'd0);

    stream("bp", 64'hFFFF_FFFF_FFFF_FA0D, 1'b1, 0);
    stream("full", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10);
    chk("stream_sat_flag", 64'(sat_flag), 64'd0);

    // Two beats in flight, downstream stalled, then reset mid-cycle.
    out_ready = 1'b0;
    mode = t_mode[0]; leak = t_leak[0]; x_in = t_x[0]; g_in = t_g[0]; in_valid = 1'b1;
    @(posedge clk); #1;
    mode = t_mode[1]; leak = t_leak[1]; x_in = t_x[1]; g_in = t_g[1];
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_vld", 64'(out_valid), 64'd1);
    chk("inflight_y", y_out, t_y[0]);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vld", 64'(out_valid), 64'd0);
    chk("async_rst_y", y_out, 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    run_beat("post_rst", t_mode[3], t_leak[3], t_x[3], t_g[3], t_y[3], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
